// File: rtl/fabric_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fabric_cfg_pkg
// Shared constants and types for the fabric tile configuration loader.
//   CFG_W    : switch-block configuration width
//   MEM_W    : logic-block LUT memory width
//   FRAME_W  : serial frame length (cfg, mem, sync, parity)
//   *_OFS    : bit offsets of the fields inside a frame (bit 0 is sent first)
//   CNT_W    : width of the frame bit counter
//   state_e  : loader FSM states
// -----------------------------------------------------------------------------
package fabric_cfg_pkg;

  localparam int CFG_W    = 108;
  localparam int MEM_W    = 4;
  localparam int FRAME_W  = CFG_W + MEM_W + 2;

  localparam int MEM_OFS  = CFG_W;
  localparam int SYNC_OFS = CFG_W + MEM_W;
  localparam int PAR_OFS  = FRAME_W - 1;

  localparam int CNT_W    = $clog2(FRAME_W);

  // The parity bit only feeds the running parity; it is never stored.
  localparam int SHADOW_W = FRAME_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // True when the counter points at the final (parity) bit of the frame.
  function automatic logic is_last_bit(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(PAR_OFS);
  endfunction

endpackage

// File: rtl/cfg_shadow_sr.sv
// -----------------------------------------------------------------------------
// cfg_shadow_sr
// Indexed-write shadow register with a running XOR of every written bit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear stored data and parity accumulator
//   wr         : write bit_i at position idx and fold it into the parity
//   idx        : bit position of the write (positions >= W only touch parity)
//   bit_i      : bit value to write
//   data       : stored bits
//   parity     : XOR of all bits written since the last clr
// -----------------------------------------------------------------------------
module cfg_shadow_sr
  import fabric_cfg_pkg::*;
#(
  parameter int W     = SHADOW_W,
  parameter int IDX_W = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [IDX_W-1:0] idx,
  input  logic             bit_i,
  output logic [W-1:0]     data,
  output logic             parity
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic [W-1:0] sel;
  logic         parity_q;
  logic         parity_d;

  // One-hot write select; an index past the stored range hits no bit.
  for (genvar gi = 0; gi < W; gi++) begin : g_sel
    assign sel[gi] = wr && (idx == IDX_W'(gi));
  end

  always_comb begin
    data_d   = data_q;
    parity_d = parity_q;
    if (clr) begin
      data_d   = '0;
      parity_d = 1'b0;
    end else if (wr) begin
      data_d   = (data_q & ~sel) | (sel & {W{bit_i}});
      parity_d = parity_q ^ bit_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      parity_q <= parity_d;
    end
  end

  assign data   = data_q;
  assign parity = parity_q;

endmodule

// File: rtl/fabric_cfg_loader.sv
// -----------------------------------------------------------------------------
// fabric_cfg_loader
// Serial, parity-protected configuration loader for one fabric tile.
// A frame is assembled in a shadow register; a frame with even overall parity
// is committed to the live outputs in a single edge, a bad frame only pulses
// err and leaves the live configuration alone.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : pulse, begin or restart a frame load
//   abort               : pulse, drop the current frame (wins over start)
//   bit_in, bit_valid   : serial frame bit and its qualifier
//   bit_ready           : loader accepts a bit this cycle (LOAD only)
//   cfg_out/mem_out/sync_out : live tile configuration
//   busy                : high in LOAD or CHECK
//   done / err          : one-cycle pulses, frame committed / parity failure
//   cfg_loaded          : sticky, a frame has been committed since reset
// -----------------------------------------------------------------------------
module fabric_cfg_loader
  import fabric_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [CFG_W-1:0] cfg_out,
  output logic [MEM_W-1:0] mem_out,
  output logic             sync_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cfg_loaded
);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic               sr_clr;
  logic               sr_wr;
  logic [SHADOW_W-1:0] shadow;
  logic               par_acc;
  logic               xfer;

  logic [CFG_W-1:0]   cfg_q;
  logic [MEM_W-1:0]   mem_q;
  logic               sync_q;
  logic               done_q;
  logic               err_q;
  logic               loaded_q;

  assign xfer = bit_valid && bit_ready;

  cfg_shadow_sr #(
    .W     (SHADOW_W),
    .IDX_W (CNT_W)
  ) u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (sr_clr),
    .wr     (sr_wr),
    .idx    (cnt_q),
    .bit_i  (bit_in),
    .data   (shadow),
    .parity (par_acc)
  );

  // State register and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A restart in LOAD takes priority over a bit offered in
  // the same cycle, so that bit is dropped along with the partial frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_clr  = 1'b0;
    sr_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          cnt_d   = '0;
          sr_clr  = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          cnt_d  = '0;
          sr_clr = 1'b1;
        end else if (xfer) begin
          sr_wr = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (is_last_bit(cnt_q)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        // start and abort are deliberately ignored here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, from state only.
  always_comb begin
    bit_ready = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      LOAD: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
      end
      CHECK: begin
        busy = 1'b1;
      end
      default: begin
        bit_ready = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Commit register: the CHECK cycle decides, the edge leaving CHECK applies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      mem_q    <= '0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == CHECK) begin
        if (!par_acc) begin
          cfg_q    <= shadow[CFG_W-1:0];
          mem_q    <= shadow[MEM_OFS +: MEM_W];
          sync_q   <= shadow[SYNC_OFS];
          done_q   <= 1'b1;
          loaded_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign cfg_out    = cfg_q;
  assign mem_out    = mem_q;
  assign sync_out   = sync_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cfg_loaded = loaded_q;

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_fabric_cfg_loader
// Self-checking bench: a vector table, hand-written corner sequences and
// random frames, all compared against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_fabric_cfg_loader;
  import fabric_cfg_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_ready;
  logic [CFG_W-1:0] cfg_out;
  logic [MEM_W-1:0] mem_out;
  logic             sync_out;
  logic             busy;
  logic             done;
  logic             err;
  logic             cfg_loaded;

  fabric_cfg_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .cfg_out    (cfg_out),
    .mem_out    (mem_out),
    .sync_out   (sync_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cfg_loaded (cfg_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the live tile state.
  logic [CFG_W-1:0] m_cfg = '0;
  logic [MEM_W-1:0] m_mem = '0;
  logic             m_sync = 1'b0;
  logic             m_loaded = 1'b0;

  typedef struct {
    logic [CFG_W-1:0] cfg;
    logic [MEM_W-1:0] mem;
    logic             sync;
    logic             par;
    bit               thr;
    bit               exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_live(input string tag);
    chk({tag, "_cfg"}, cfg_out, m_cfg);
    chk({tag, "_mem"}, mem_out, m_mem);
    chk({tag, "_sync"}, sync_out, m_sync);
    chk({tag, "_loaded"}, cfg_loaded, m_loaded);
  endtask

  function automatic logic [FRAME_W-1:0] make_frame(input logic [CFG_W-1:0] c,
                                                     input logic [MEM_W-1:0] m,
                                                     input logic s, input logic p);
    return {p, s, m, c};
  endfunction

  task automatic start_pulse(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_ready_after_start"}, bit_ready, 1'b1);
    chk({tag, "_busy_after_start"}, busy, 1'b1);
  endtask

  // Drives bits 0..n-1 of frame f; with thr set every bit is preceded by an
  // idle cycle with bit_valid low.
  task automatic load_bits(input logic [FRAME_W-1:0] f, input int n, input bit thr,
                           input string tag);
    int ready_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (thr) begin
        bit_valid = 1'b0;
        bit_in    = ~f[i];
        if (bit_ready !== 1'b1) ready_bad++;
        step();
      end
      bit_valid = 1'b1;
      bit_in    = f[i];
      if (bit_ready !== 1'b1) ready_bad++;
      step();
    end
    bit_valid = 1'b0;
    chk({tag, "_ready_lost_in_load"}, 128'(ready_bad), 128'd0);
    chk({tag, "_done_in_load"}, done, 1'b0);
    chk({tag, "_err_in_load"}, err, 1'b0);
    check_live({tag, "_load"});
  endtask

  // Called right after the final bit was accepted: expects the CHECK cycle,
  // then the done/err pulse on the following cycle.
  task automatic finish_frame(input logic [FRAME_W-1:0] f, input bit good,
                              input bit start_in_check, input string tag);
    chk({tag, "_busy_check"}, busy, 1'b1);
    chk({tag, "_ready_check"}, bit_ready, 1'b0);
    chk({tag, "_done_early"}, done, 1'b0);
    if (start_in_check) start = 1'b1;
    step();
    start = 1'b0;
    if (good) begin
      m_cfg    = f[CFG_W-1:0];
      m_mem    = f[MEM_OFS +: MEM_W];
      m_sync   = f[SYNC_OFS];
      m_loaded = 1'b1;
    end
    chk({tag, "_done"}, done, good);
    chk({tag, "_err"}, err, !good);
    check_live(tag);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_ready"}, bit_ready, 1'b0);
    $display("frame %s good=%0d done=%0d err=%0d cfg_loaded=%0d", tag, good, done, err, cfg_loaded);
    step();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_err_pulse"}, err, 1'b0);
  endtask

  task automatic send_frame(input logic [FRAME_W-1:0] f, input bit thr, input bit good,
                            input bit start_in_check, input string tag);
    start_pulse(tag);
    load_bits(f, FRAME_W, thr, tag);
    finish_frame(f, good, start_in_check, tag);
  endtask

  initial begin
    logic [CFG_W-1:0]   c;
    logic [FRAME_W-1:0] f;
    logic [FRAME_W-1:0] f_good;
    logic [FRAME_W-1:0] f_ones;
    logic [127:0]       r;

    // Test-plan cfg pattern: bits 4, 18, 35, 38, 52.
    c = '0;
    c[4] = 1'b1; c[18] = 1'b1; c[35] = 1'b1; c[38] = 1'b1; c[52] = 1'b1;
    vecs[0] = '{cfg: c,  mem: 4'b0110, sync: 1'b0, par: 1'b1, thr: 1'b0, exp_done: 1'b1};
    vecs[1] = '{cfg: c,  mem: 4'b0110, sync: 1'b0, par: 1'b0, thr: 1'b0, exp_done: 1'b0};
    vecs[2] = '{cfg: c,  mem: 4'b0110, sync: 1'b0, par: 1'b1, thr: 1'b1, exp_done: 1'b1};
    vecs[3] = '{cfg: '0, mem: 4'b0000, sync: 1'b1, par: 1'b1, thr: 1'b0, exp_done: 1'b1};
    vecs[4] = '{cfg: '1, mem: 4'b1111, sync: 1'b0, par: 1'b0, thr: 1'b0, exp_done: 1'b1};
    vecs[5] = '{cfg: '1, mem: 4'b1111, sync: 1'b0, par: 1'b1, thr: 1'b1, exp_done: 1'b0};
    f_good = make_frame(c, 4'b0110, 1'b0, 1'b1);
    f_ones = make_frame('1, 4'b1111, 1'b0, 1'b0);

    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    check_live("reset");
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", bit_ready, 1'b0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 1'b0);

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      f = make_frame(vecs[v].cfg, vecs[v].mem, vecs[v].sync, vecs[v].par);
      send_frame(f, vecs[v].thr, vecs[v].exp_done, 1'b0, $sformatf("vec%0d", v));
    end

    // Restart: 50 bits of another frame, start again, full good frame.
    start_pulse("restart_a");
    load_bits(f_ones, 50, 1'b0, "restart_a");
    start_pulse("restart_b");
    load_bits(f_good, FRAME_W, 1'b0, "restart_b");
    finish_frame(f_good, 1'b1, 1'b0, "restart");

    // Abort after 60 bits.
    start_pulse("abort");
    load_bits(f_ones, 60, 1'b0, "abort");
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", bit_ready, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_err", err, 1'b0);
    check_live("abort");
    step();
    chk("abort_done2", done, 1'b0);
    chk("abort_err2", err, 1'b0);
    $display("frame abort busy=%0d done=%0d err=%0d", busy, done, err);

    // start and abort together in LOAD: abort wins.
    start_pulse("both");
    load_bits(f_ones, 10, 1'b0, "both");
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("both_busy", busy, 1'b0);

    // start during CHECK is ignored: commit happens and the FSM goes IDLE.
    send_frame(f_ones, 1'b0, 1'b1, 1'b1, "start_in_check");
    send_frame(f_good, 1'b0, 1'b1, 1'b1, "start_in_check2");

    // Asynchronous reset at bit 80: outputs drop before any clock edge.
    start_pulse("areset");
    load_bits(f_ones, 80, 1'b0, "areset");
    #2;
    rst_n = 1'b0;
    #1;
    m_cfg = '0; m_mem = '0; m_sync = 1'b0; m_loaded = 1'b0;
    check_live("areset");
    chk("areset_busy", busy, 1'b0);
    chk("areset_ready", bit_ready, 1'b0);
    #3;
    rst_n = 1'b1;
    step();
    chk("areset_idle", busy, 1'b0);
    $display("frame areset cfg_loaded=%0d busy=%0d", cfg_loaded, busy);
    send_frame(f_good, 1'b0, 1'b1, 1'b0, "after_areset");

    // Random frames; parity is deliberately wrong about a quarter of the time.
    for (int k = 0; k < 24; k++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      c = r[CFG_W-1:0];
      f = make_frame(c, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      f[PAR_OFS] = ($countones(f) % 2 == 1) ^ ($urandom_range(0, 3) == 0);
      send_frame(f, 1'($urandom_range(0, 1)), ($countones(f) % 2 == 0), 1'b0,
                 $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
